// File: rtl/perf_event_dumper.sv
// perf_event_dumper: per-event saturating counters with a snapshot-and-dump
// port. A dump request in IDLE captures every counter into a snapshot bank.
// The bank is then streamed out one record per handshake, from index 0 to
// index EVENT_NUM-1.
//
// Optional feature: define PERF_DUMP_CLEAR_EN to clear the live counters at
// the snapshot edge, so each dump reports per-interval counts. When it is
// undefined, the counters are cumulative until reset.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   event_i     per-event increment pulses
//   dump_req    request a snapshot and dump (ignored while busy)
//   dump_valid  dump record present
//   dump_ready  consumer accepts the record
//   dump_idx    counter index of the current record
//   dump_data   snapshot value for dump_idx
//   dump_last   current record is the final index
//   busy        FSM is not in IDLE
module perf_event_dumper #(
  parameter int unsigned EVENT_NUM = 8,
  parameter int unsigned CNT_WIDTH = 32,
  localparam int unsigned IDX_W = (EVENT_NUM > 1) ? $clog2(EVENT_NUM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] event_i,
  input  logic                 dump_req,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [IDX_W-1:0]     dump_idx,
  output logic [CNT_WIDTH-1:0] dump_data,
  output logic                 dump_last,
  output logic                 busy
);

  typedef enum logic [0:0] {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q   [EVENT_NUM];
  logic [CNT_WIDTH-1:0] cnt_inc [EVENT_NUM];
  logic [CNT_WIDTH-1:0] cnt_d   [EVENT_NUM];
  logic [CNT_WIDTH-1:0] snap_q  [EVENT_NUM];
  logic                 load;
  logic                 is_last;

  assign is_last = (idx_q == IDX_W'(EVENT_NUM - 1));

  // Saturating increment; the snapshot captures this value so the event of
  // the request cycle is included.
  always_comb begin
    for (int k = 0; k < EVENT_NUM; k++) begin
      cnt_inc[k] = cnt_q[k];
      if (event_i[k] && (cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
        cnt_inc[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  // Next live counter value, optionally cleared at the snapshot edge.
  always_comb begin
    for (int k = 0; k < EVENT_NUM; k++) begin
`ifdef PERF_DUMP_CLEAR_EN
      cnt_d[k] = load ? '0 : cnt_inc[k];
`else
      cnt_d[k] = cnt_inc[k];
`endif
    end
  end

  // Dump FSM next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < EVENT_NUM; k++) begin
        cnt_q[k]  <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int k = 0; k < EVENT_NUM; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (load) begin
          snap_q[k] <= cnt_inc[k];
        end
      end
    end
  end

  // Outputs come straight from state/index registers and the snapshot mux.
  assign dump_valid = (state_q == SEND);
  assign busy       = (state_q != IDLE);
  assign dump_last  = dump_valid && is_last;
  assign dump_idx   = idx_q;
  assign dump_data  = snap_q[idx_q];

endmodule

// File: tb/tb_perf_event_dumper.sv
// Testbench for perf_event_dumper. It uses directed scenarios plus random
// traffic. Every scenario is checked against a behavioural model of the
// counters and of the dump record stream.
module tb_perf_event_dumper;

  localparam int EN   = 8;
  localparam int CW   = 4;
  localparam int IW   = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [EN-1:0] event_i;
  logic          dump_req;
  logic          dump_valid;
  logic          dump_ready;
  logic [IW-1:0] dump_idx;
  logic [CW-1:0] dump_data;
  logic          dump_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Model: live counts, snapshot bank, and the position in the record stream.
  int m_cnt  [EN];
  int m_snap [EN];
  bit m_busy;
  int m_idx;

  always #5 clk = ~clk;

  perf_event_dumper #(.EVENT_NUM(EN), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .event_i    (event_i),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(dump_valid), 64'(m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    if (m_busy) begin
      chk("idx", 64'(dump_idx), 64'(m_idx));
      chk("data", 64'(dump_data), 64'(m_snap[m_idx]));
      chk("last", 64'(dump_last), 64'(m_idx == EN - 1));
    end else begin
      chk("last_idle", 64'(dump_last), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic r, input logic [EN-1:0] ev, input logic rq, input logic rd);
    bit hs;
    rst        = r;
    event_i    = ev;
    dump_req   = rq;
    dump_ready = rd;
    hs = m_busy && rd;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < EN; k++) begin
        m_cnt[k]  = 0;
        m_snap[k] = 0;
      end
      m_busy = 1'b0;
      m_idx  = 0;
    end else begin
      int nv [EN];
      for (int k = 0; k < EN; k++) begin
        nv[k] = m_cnt[k] + (ev[k] ? 1 : 0);
        if (nv[k] > MAXV) nv[k] = MAXV;
      end
      if (!m_busy && rq) begin
        for (int k = 0; k < EN; k++) begin
          m_snap[k] = nv[k];
`ifdef PERF_DUMP_CLEAR_EN
          nv[k] = 0;
`endif
        end
        m_busy = 1'b1;
        m_idx  = 0;
      end else if (hs) begin
        if (m_idx == EN - 1) m_busy = 1'b0;
        else m_idx++;
      end
      for (int k = 0; k < EN; k++) m_cnt[k] = nv[k];
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, 1'b0, 1'b0);
    chk("rst_data", 64'(dump_data), 64'd0);
    chk("rst_idx", 64'(dump_idx), 64'd0);
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b1; event_i = '0; dump_req = 1'b0; dump_ready = 1'b0;
    m_busy = 1'b0; m_idx = 0;
    for (int k = 0; k < EN; k++) begin m_cnt[k] = 0; m_snap[k] = 0; end

    // Reset state, then five pulses on event 2 and a free-flowing dump.
    do_reset();
    repeat (5) cycle(1'b0, EN'(8'h04), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("first_rec_idx", 64'(dump_idx), 64'd0);
    busy_cycles = 0;
    for (int i = 0; i < EN; i++) begin
      if (dump_valid) busy_cycles++;
      if (dump_valid && dump_idx == 3'd2) chk("ev2_count", 64'(dump_data), 64'd5);
      // The request raised with the final handshake must be ignored.
      cycle(1'b0, '0, (i == EN - 1), 1'b1);
    end
    chk("dump_len", 64'(busy_cycles), 64'(EN));
    chk("dump_done", 64'(dump_valid), 64'd0);

    // Back-pressure on the first record, with requests raised while busy.
    cycle(1'b0, '0, 1'b1, 1'b0);
    repeat (4) begin
      cycle(1'b0, EN'(8'h81), 1'b1, 1'b0);
      chk("stall_idx", 64'(dump_idx), 64'd0);
    end
    repeat (EN) cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("no_extra_dump", 64'(dump_valid), 64'd0);

    // Saturation of event 0.
    do_reset();
    repeat (20) cycle(1'b0, EN'(8'h01), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("sat_ev0", 64'(dump_data), 64'(MAXV));
    repeat (EN) cycle(1'b0, '0, 1'b0, 1'b1);

    // Event coinciding with the request is included in the snapshot.
    do_reset();
    repeat (3) cycle(1'b0, EN'(8'h02), 1'b0, 1'b0);
    cycle(1'b0, EN'(8'h02), 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("coincident_ev1", 64'(dump_data), 64'd4);
    repeat (EN - 1) cycle(1'b0, '0, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, EN'(8'h02), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
`ifdef PERF_DUMP_CLEAR_EN
    chk("second_dump_ev1", 64'(dump_data), 64'd2);
`else
    chk("second_dump_ev1", 64'(dump_data), 64'd6);
`endif
    repeat (EN - 1) cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset in the middle of a dump aborts it; the next dump is all zeros.
    repeat (4) cycle(1'b0, EN'(8'hFF), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    chk("abort_at_idx3", 64'(dump_idx), 64'd3);
    cycle(1'b1, EN'(8'hFF), 1'b1, 1'b1);
    chk("abort_valid", 64'(dump_valid), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < EN; i++) begin
      chk("zero_dump", 64'(dump_data), 64'd0);
      cycle(1'b0, '0, 1'b0, 1'b1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            EN'($urandom),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perf_event_dumper.md
PERF_EVENT_DUMPER -- requirements
Module: perf_event_dumper

Interface
REQ-001 SHALL have parameter EVENT_NUM, default 8: number of event inputs and counters; legal 1..64.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of each counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port event_i  input  EVENT_NUM  per-event increment pulse, sampled every cycle.
REQ-006 SHALL have port dump_req  input  1  request a snapshot and dump of all counters.
REQ-007 SHALL have port dump_valid  output  1  dump record present.
REQ-008 SHALL have port dump_ready  input  1  consumer accepts the record.
REQ-009 SHALL have port dump_idx  output  $clog2(EVENT_NUM) (min 1)  counter index of the current record.
REQ-010 SHALL have port dump_data  output  CNT_WIDTH  snapshot value of counter dump_idx.
REQ-011 SHALL have port dump_last  output  1  current record is index EVENT_NUM-1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL keep one live counter per event; when event_i[k]=1 in a cycle, counter k SHALL increase by 1 at that edge.
REQ-014 SHALL saturate each live counter at 2^CNT_WIDTH-1; no wrap-around.
REQ-015 SHALL implement FSM states IDLE and SEND.
REQ-016 IDLE: dump_req=1 at edge t SHALL load snapshot[k] = value counter k would take at t (event of cycle t included, saturation applied), set dump_idx=0, and enter SEND.
REQ-017 SHALL ignore dump_req while in SEND; no queuing.
REQ-018 SEND: dump_valid SHALL be 1; dump_data SHALL equal snapshot[dump_idx]; dump_last SHALL equal (dump_idx==EVENT_NUM-1).
REQ-019 SEND: with dump_valid=1 and dump_ready=0, dump_idx/dump_data/dump_last SHALL stay stable.
REQ-020 SEND: handshake with dump_last=0 SHALL increment dump_idx at that edge.
REQ-021 SEND: handshake with dump_last=1 SHALL return to IDLE; dump_valid=0 the next cycle; a dump_req in that handshake cycle SHALL be ignored.
REQ-022 Live counters SHALL keep counting in every state; snapshot registers SHALL change only at the REQ-016 load.
REQ-023 First record SHALL be valid one cycle after the accepted dump_req; with dump_ready held high a full dump SHALL take exactly EVENT_NUM cycles.
REQ-024 EVENT_NUM=1: first record SHALL have dump_idx=0 and dump_last=1.
REQ-025 Outputs SHALL be driven only from registers and the snapshot mux; no combinational path from dump_ready to dump_valid.

Reset
REQ-026 rst=1 at an edge SHALL clear all live counters, all snapshot registers, and dump_idx to 0, and force IDLE; this takes priority over event_i and dump_req in the same cycle.
REQ-027 After reset, dump_valid, dump_last, and busy SHALL be 0, and dump_data SHALL be 0.
REQ-028 Reset during SEND SHALL abort the dump with no further records; dump_valid=0 from the next cycle.

Configuration
REQ-029 Macro PERF_DUMP_CLEAR_EN defined: at the REQ-016 snapshot edge every live counter SHALL be cleared to 0 after its value is captured, so each dump reports per-interval counts.
REQ-030 Macro PERF_DUMP_CLEAR_EN undefined: live counters SHALL never clear except on reset, so dumps report cumulative counts; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, pulse event_i[2] for 5 cycles, then dump_req with dump_ready=1: records idx 0..7 in 8 consecutive cycles, data[2]=5 and all others 0, dump_last only on idx 7.
REQ-032 Hold dump_ready=0 for 4 cycles after the first record: idx=0 and its data stay stable, then 8 handshakes complete; a dump_req during SEND produces no extra dump.
REQ-033 Use CNT_WIDTH=4 and hold event_i[0]=1 for 20 cycles, then dump: data[0]=15 (saturated).
REQ-034 Raise event_i[1] and dump_req in the same cycle after 3 prior pulses: data[1]=4. With PERF_DUMP_CLEAR_EN, a second dump after 2 more pulses gives 2; without it, the second dump gives 6.
REQ-035 Assert rst at idx 3 of a dump: dump_valid=0 the next cycle, FSM in IDLE, and a new dump reports all zeros.
